// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier and restoring divider with HI/LO results.
// Works on magnitudes one bit per cycle; signs are re-applied in a single fix-up cycle.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_unsign,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_iter;

    logic               div_r;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;
    logic [WIDTH-1:0]   a_orig;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic en);
        return en ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        return en ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    assign accept    = (state == IDLE) && start && !flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign sign_a    = !is_unsign && a[WIDTH-1];
    assign sign_b    = !is_unsign && b[WIDTH-1];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            if (accept) begin
                cnt <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // One iteration: multiply adds the multiplicand under the multiplier LSB and
    // shifts right; divide shifts the next dividend bit into the remainder and
    // keeps the trial difference only when it does not go negative.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_diff  = div_shift - {2'b00, opb};
    assign div_ge    = !div_diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (accept) begin
            div_r    <= op_div;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div_zero <= (b == '0);
            a_orig   <= a;
            opb      <= neg_w(b, sign_b);
            acc      <= {{WIDTH{1'b0}}, neg_w(a, sign_a)};
            rem      <= '0;
        end else if (state == CALC) begin
            if (div_r) begin
                rem             <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
                acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
            end else begin
                acc <= {mul_sum, acc[WIDTH-1:1]};
            end
        end
    end

    // Signed overflow (-2^(W-1) / -1) needs no special case: the unsigned
    // quotient magnitude 2^(W-1) is left un-negated and reads back as -2^(W-1).
    assign mul_res = neg_2w(acc, neg_q);

    always_comb begin
        hi_res = mul_res[2*WIDTH-1:WIDTH];
        lo_res = mul_res[WIDTH-1:0];
        if (div_r) begin
            if (div_zero) begin
                hi_res = a_orig;
                lo_res = '1;
            end else begin
                hi_res = neg_w(rem[WIDTH-1:0], neg_r);
                lo_res = neg_w(acc[WIDTH-1:0], neg_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if ((state == FIX) && !flush) begin
            hi <= hi_res;
            lo <= lo_res;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: 32-bit and 8-bit instances checked against
// a plain-arithmetic reference model, including handshake, flush and reset cases.
module tb_muldiv_iter;

    localparam int W  = 32;
    localparam int W8 = 8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, op_div = 1'b0, is_unsign = 1'b0, flush = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi, lo;
    logic        busy, done;

    logic        start8 = 1'b0, op_div8 = 1'b0, uns8 = 1'b0, flush8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  hi8, lo8;
    logic        busy8, done8;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        m32, m8;
    logic [31:0] hold_hi = '0, hold_lo = '0;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_div(op_div), .is_unsign(is_unsign),
        .flush(flush), .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    muldiv_iter #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_div(op_div8), .is_unsign(uns8),
        .flush(flush8), .a(a8), .b(b8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: sign-extend to 64 bits and use native *, /, % (truncating division).
    function automatic logic [63:0] model(input int w, input bit dv, input bit un,
                                          input logic [31:0] aa, input logic [31:0] bb);
        logic [63:0]        mw, ua, ub, t, hi_v, lo_v;
        logic signed [63:0] sa, sb, p, qq, rr;
        mw = (64'd1 << w) - 64'd1;
        ua = {32'd0, aa} & mw;
        ub = {32'd0, bb} & mw;
        t  = ua << (64 - w);
        sa = $signed(t) >>> (64 - w);
        t  = ub << (64 - w);
        sb = $signed(t) >>> (64 - w);
        if (!dv) begin
            if (un) p = $signed(ua * ub);
            else    p = sa * sb;
            hi_v = (p >> w) & mw;
            lo_v = p & mw;
        end else if (ub == 64'd0) begin
            lo_v = mw;
            hi_v = ua;
        end else if (un) begin
            lo_v = ua / ub;
            hi_v = ua % ub;
        end else begin
            qq   = sa / sb;
            rr   = sa % sb;
            lo_v = qq & mw;
            hi_v = rr & mw;
        end
        return {hi_v[31:0], lo_v[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 300));
            default: return $urandom();
        endcase
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done32 actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                m32 = q32.pop_front();
                chk("hi32", 64'(hi), 64'(m32.hi));
                chk("lo32", 64'(lo), 64'(m32.lo));
                chk("done_cycle32", 64'(cyc), 64'(m32.cyc));
                chk("busy_in_done32", 64'(busy), 64'd1);
                hold_hi = m32.hi;
                hold_lo = m32.lo;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done8) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done8 actual=done required=no_done (cycle %0d)", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("hi8", 64'(hi8), 64'(m8.hi));
                chk("lo8", 64'(lo8), 64'(m8.lo));
                chk("done_cycle8", 64'(cyc), 64'(m8.cyc));
            end
        end
    end

    task automatic issue32(input bit dv, input bit un, input logic [31:0] aa, input logic [31:0] bb,
                           output int acc_cyc);
        logic [63:0] r;
        exp_t        e;
        @(negedge clk);
        op_div = dv; is_unsign = un; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        acc_cyc = cyc;
        r       = model(W, dv, un, aa, bb);
        e.hi    = r[63:32];
        e.lo    = r[31:0];
        e.cyc   = cyc + W + 1;
        q32.push_back(e);
        chk("busy_after_accept32", 64'(busy), 64'd1);
    endtask

    task automatic issue8(input bit dv, input bit un, input logic [7:0] aa, input logic [7:0] bb);
        logic [63:0] r;
        exp_t        e;
        @(negedge clk);
        op_div8 = dv; uns8 = un; a8 = aa; b8 = bb; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        r      = model(W8, dv, un, {24'd0, aa}, {24'd0, bb});
        e.hi   = r[63:32];
        e.lo   = r[31:0];
        e.cyc  = cyc + W8 + 1;
        q8.push_back(e);
    endtask

    task automatic wait_idle32();
        int n = 0;
        while (q32.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q32.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout32 actual=no_done required=done (cycle %0d)", cyc);
            q32.delete();
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_after_done32", 64'(busy), 64'd0);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout8 actual=no_done required=done (cycle %0d)", cyc);
            q8.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    bit          dl_dv[8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    bit          dl_un[8] = '{1, 0, 0, 1, 1, 0, 0, 0};
    logic [31:0] dl_a[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                              32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dl_b[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};

    initial begin
        int e;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy8", 64'(busy8), 64'd0);
        rst_n = 1'b1;

        // signed -3 * 7 with an ignored start re-pulse mid-operation
        issue32(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, e);
        wait_cyc(e + 4);
        op_div = 1'b1; a = 32'd5; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_while_busy_hi", 64'(hi), 64'(hold_hi));
        chk("hold_while_busy_lo", 64'(lo), 64'(hold_lo));
        chk("busy_mid_op", 64'(busy), 64'd1);
        wait_idle32();

        for (int i = 0; i < 8; i++) begin
            issue32(dl_dv[i], dl_un[i], dl_a[i], dl_b[i], e);
            wait_idle32();
        end

        // flush mid-divide: no done, hi/lo untouched
        issue32(1'b1, 1'b0, 32'hFFFF_0123, 32'd37, e);
        wait_cyc(e + 9);
        flush = 1'b1;
        @(posedge clk);
        #1;
        void'(q32.pop_back());
        chk("busy_after_flush", 64'(busy), 64'd0);
        chk("hold_after_flush_hi", 64'(hi), 64'(hold_hi));
        chk("hold_after_flush_lo", 64'(lo), 64'(hold_lo));
        @(negedge clk);
        flush = 1'b0;
        issue32(1'b0, 1'b1, 32'd1000, 32'd3000, e);
        wait_idle32();

        // start together with flush in IDLE is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_beats_start", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;

        // start held in the DONE cycle is ignored
        issue32(1'b1, 1'b1, 32'd1000, 32'd9, e);
        wait_cyc(e + W + 1);
        op_div = 1'b0; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (W + 5) @(posedge clk);

        // asynchronous reset in the middle of a divide
        issue32(1'b1, 1'b0, 32'h8765_4321, 32'd13, e);
        wait_cyc(e + 19);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_hi", 64'(hi), 64'd0);
        chk("async_rst_lo", 64'(lo), 64'd0);
        q32.delete();
        hold_hi = '0;
        hold_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue32(1'b0, 1'b1, 32'd6, 32'd7, e);
        wait_idle32();

        for (int i = 0; i < 40; i++) begin
            issue32(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(), e);
            wait_idle32();
        end

        issue8(1'b0, 1'b0, 8'h80, 8'h80);
        wait_idle8();
        issue8(1'b1, 1'b0, 8'h80, 8'hFF);
        wait_idle8();
        for (int i = 0; i < 12; i++) begin
            issue8(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()), 8'($urandom()));
            wait_idle8();
        end

        repeat (60) @(posedge clk);
        chk("queue32_drained", 64'(q32.size()), 64'd0);
        chk("queue8_drained", 64'(q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
